// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned SUB_WIDTH = 8;
  localparam int unsigned SUB_CNT_W = $clog2(SUB_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width able to hold the values 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - b_in, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  // Difference bit and borrow generation.
  always_comb begin
    d     = x ^ y ^ b_in;
    b_out = (~x & y) | (~(x ^ y) & b_in);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per cycle, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             b_out,
  output logic             ovf
`else
  output logic             b_out
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             bit_d;
  logic             bit_b;
  logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  full_subtractor u_fs (
    .x     (a_sr[0]),
    .y     (b_sr[0]),
    .b_in  (borrow),
    .d     (bit_d),
    .b_out (bit_b)
  );

  // Result register after this cycle's bit enters at the MSB end.
  always_comb begin
    res_next = {bit_d, res_sr[WIDTH-1:1]};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // Control FSM and datapath; results only move on the RUN-to-DONE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      b_out  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res_sr <= res_next;
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          borrow <= bit_b;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= res_next;
            b_out <= bit_b;
`ifdef SERIAL_SUB_OVF_EN
            // Final difference MSB is the bit produced this cycle.
            ovf   <= (a_msb != b_msb) && (bit_d != a_msb);
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8), scoreboard based.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         b_out;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  exp_t sb[$];
  int   checks     = 0;
  int   errors     = 0;
  int   done_count = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
    .b_out (b_out),
    .ovf   (ovf)
`else
    .b_out (b_out)
`endif
  );

  // Reference model of one subtraction.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    exp_t e;
    e.diff  = ma - mb;
    e.b_out = (ma < mb);
    e.ovf   = (ma[W-1] != mb[W-1]) && (e.diff[W-1] != ma[W-1]);
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 with empty scoreboard, diff=%h", diff);
      end else begin
        e = sb.pop_front();
        if (diff !== e.diff) begin
          errors++;
          $display("FAIL result_diff: got %h expected %h", diff, e.diff);
        end
        checks++;
        if (b_out !== e.b_out) begin
          errors++;
          $display("FAIL result_borrow: got %b expected %b", b_out, e.b_out);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== e.ovf) begin
          errors++;
          $display("FAIL result_ovf: got %b expected %b", ovf, e.ovf);
        end
`endif
      end
    end
  end

  // Drive one start pulse at the current negedge; returns on the next negedge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    sb.push_back(model(ta, tb_v));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) until done is observed at a negedge.
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h01;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (diff !== 8'h00 || b_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: diff=%h b_out=%b required 00 0", diff, b_out);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b required 0", ovf);
    end
`endif
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic();
    int nb;
    issue(8'h05, 8'h03);
    nb = 0;
    while (busy === 1'b1 && nb < 20) begin
      nb++;
      @(negedge clk);
    end
    checks++;
    if (nb != 8) begin
      errors++;
      $display("FAIL busy_length: busy for %0d cycles, required 8", nb);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timing: done=%b in cycle 9, required 1", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || diff !== 8'h02) begin
      errors++;
      $display("FAIL done_pulse_hold: done=%b diff=%h required 0 02", done, diff);
    end
  endtask

  task automatic test_borrow();
    issue(8'h00, 8'h01);
    wait_done(20);
    @(negedge clk);
  endtask

  task automatic test_overflow();
    issue(8'h80, 8'h01);
    wait_done(20);
    @(negedge clk);
    issue(8'h7F, 8'hFF);
    wait_done(20);
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int dc;
    dc = done_count;
    issue(8'h10, 8'h01);
    repeat (2) @(negedge clk);
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    repeat (12) @(negedge clk);
    checks++;
    if (done_count != dc + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: dones=%0d busy=%b required %0d 0", done_count - dc, busy, 1);
    end
  endtask

  task automatic test_reset_abort();
    int dc;
    issue(8'h33, 8'h11);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    dc = done_count;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || diff !== 8'h00 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b diff=%h done=%b required 0 00 0", busy, diff, done);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (done_count != dc) begin
      errors++;
      $display("FAIL abort_no_done: %0d dones, required 0", done_count - dc);
    end
    issue(8'h09, 8'h04);
    wait_done(20);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue(8'h40, 8'h0F);
    wait_done(20);
    a     = 8'h20;
    b     = 8'h30;
    start = 1'b1;
    sb.push_back(model(8'h20, 8'h30));
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: busy=%b done=%b required 1 0", busy, done);
    end
    wait_done(20);
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      issue(W'($urandom), W'($urandom));
      wait_done(20);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results pending, required 0", sb.size());
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: request a subtraction; sampled only while busy=0.
REQ-005 SHALL have port a, input, WIDTH: minuend; sampled on the accepting edge only.
REQ-006 SHALL have port b, input, WIDTH: subtrahend; sampled on the accepting edge only.
REQ-007 SHALL have port busy, output, 1: high while a subtraction is in progress.
REQ-008 SHALL have port done, output, 1: single-cycle pulse marking a new result.
REQ-009 SHALL have port diff, output, WIDTH: result, a minus b modulo 2^WIDTH.
REQ-010 SHALL have port b_out, output, 1: final borrow; 1 iff a < b unsigned.
REQ-011 SHALL have port ovf, output, 1: signed overflow flag; present only under SERIAL_SUB_OVF_EN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE or DONE with start=1, latch a and b into shift registers, clear the borrow flop and bit counter, and enter RUN.
REQ-014 SHALL, in DONE with start=0, return to IDLE on the next edge.
REQ-015 SHALL, each RUN cycle, take one bit of each operand, LSB first, plus the borrow flop, and compute d = x^y^bin and bnext = (~x&y) | (~(x^y)&bin).
REQ-016 SHALL shift d into the internal result shift register at the MSB end, right-shift both operand registers, and increment the counter.
REQ-017 SHALL leave RUN after exactly WIDTH RUN cycles.
REQ-018 SHALL, on the RUN-to-DONE edge, load diff and b_out, and load ovf when present.
REQ-019 SHALL assert done for exactly the one cycle spent in DONE.
REQ-020 SHALL timing: start accepted at edge k gives done=1 in the cycle following edge k+WIDTH.
REQ-021 SHALL drive busy=1 exactly while in RUN.
REQ-022 SHALL ignore start and changes on a and b while in RUN.
REQ-023 SHALL hold diff, b_out and ovf stable from the DONE load until the next DONE load or reset; they do not change during RUN.
REQ-024 SHALL treat start=1 in the DONE cycle as back-to-back acceptance: done=1 and the transition to RUN occur in the same cycle.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, enter IDLE and clear busy, done, diff, b_out, ovf, the borrow flop, the counter and the shift registers to 0.
REQ-026 SHALL make rst dominant over start, abort any RUN in progress, and emit no done for the aborted operation.

Configuration
REQ-027 SHALL, with SERIAL_SUB_OVF_EN defined, provide port ovf, loaded at DONE as (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]) using the latched operands.
REQ-028 SHALL, without SERIAL_SUB_OVF_EN, omit port ovf and its logic entirely, with all other behaviour identical.

Structure
REQ-029 SHALL place in package serial_sub_pkg: the state enum typedef (IDLE, RUN, DONE), the WIDTH default constant, and the counter-width constant ($clog2(WIDTH+1)).
REQ-030 SHALL instantiate one combinational sub-module full_subtractor (ports x, y, b_in, d, b_out) for the per-bit computation in REQ-015.

Verification
REQ-031 SHALL cover, WIDTH=8: a=0x05, b=0x03, start pulse -> busy for 8 cycles; done in cycle 9; diff=0x02, b_out=0.
REQ-032 SHALL cover: a=0x00, b=0x01 -> diff=0xFF, b_out=1; with macro, ovf=0.
REQ-033 SHALL cover, macro defined: a=0x80, b=0x01 -> diff=0x7F, b_out=0, ovf=1; and a=0x7F, b=0xFF -> diff=0x80, b_out=1, ovf=1.
REQ-034 SHALL cover: start with a=0x10, b=0x01, then start with a=0xAA, b=0x55 during RUN cycle 3 -> second start ignored; diff=0x0F; exactly one done.
REQ-035 SHALL cover: rst=1 in RUN cycle 4 -> next cycle busy=0, diff=0x00, no done; a following start with a=0x09, b=0x04 -> diff=0x05.
REQ-036 SHALL cover: start held high in the done cycle with a=0x20, b=0x30 -> a new RUN begins immediately; next done gives diff=0xF0, b_out=1.
